// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the request, data and output-handshake signals shared by the
// round-robin mux arbiter and its four sources and single consumer.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic [3:0]       ack;
    logic             busy;

    // Arbiter side
    modport master (
        input  req, a, b, c, d, out_ready,
        output out_valid, out, sel, grant, ack, busy
    );

    // Sources and consumer side
    modport slave (
        output req, a, b, c, d, out_ready,
        input  out_valid, out, sel, grant, ack, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux among four requesters, with bounded
// bursts, a one-cycle IDLE bubble between grants and a valid/ready output.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                clk,
    input  logic                rst,
    mux4_rr_arbiter_if.master   bus
);
    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [3:0] BURST_LEN = 4'(MAX_BURST);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       count_q, count_d;

    logic [1:0]       winner;
    logic [WIDTH-1:0] mux_data;
    logic             out_valid;
    logic             transfer;

    // Scan downward so the lowest offset from ptr_q is written last and wins.
    always_comb begin
        winner = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr_q + 2'(i)]) winner = ptr_q + 2'(i);
        end
    end

    always_comb begin
        unique case (sel_q)
            2'd0: mux_data = bus.a;
            2'd1: mux_data = bus.b;
            2'd2: mux_data = bus.c;
            2'd3: mux_data = bus.d;
        endcase
    end

    assign out_valid     = (state_q == GRANT) && bus.req[sel_q];
    assign transfer      = out_valid && bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.out       = out_valid ? mux_data : '0;
    assign bus.ack       = transfer ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = (state_q == GRANT);

    // NOTE: every next-state signal takes its held value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    sel_d   = winner;
                    grant_d = 4'b0001 << winner;
                    count_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + 2'd1;
                    count_d = '0;
                end else if (transfer) begin
                    count_d = count_q + 4'd1;
                    if (count_d == BURST_LEN) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = sel_q + 2'd1;
                    end
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random
// traffic compared against a behavioural round-robin model.
module tb_mux4_rr_arbiter;
    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: who holds the grant, transfers so far, next scan start.
    bit m_busy;
    int m_sel;
    int m_ptr;
    int m_cnt;

    mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    // One clock period: drive at negedge, compare outputs, advance model to the next posedge.
    task automatic run_cycle(input logic [3:0] r, input logic rdy,
                             input logic [3:0] va, input logic [3:0] vb,
                             input logic [3:0] vc, input logic [3:0] vd);
        logic [3:0] srcs [4];
        logic       e_valid;
        logic [3:0] e_out, e_grant, e_ack;
        @(negedge clk);
        bus.req       = r;
        bus.out_ready = rdy;
        bus.a         = va;
        bus.b         = vb;
        bus.c         = vc;
        bus.d         = vd;
        #1;
        srcs    = '{va, vb, vc, vd};
        e_valid = m_busy && r[m_sel];
        e_out   = e_valid ? srcs[m_sel] : 4'h0;
        e_grant = m_busy ? 4'(1 << m_sel) : 4'h0;
        e_ack   = (e_valid && rdy) ? 4'(1 << m_sel) : 4'h0;
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("out",       32'(bus.out),       32'(e_out));
        check("grant",     32'(bus.grant),     32'(e_grant));
        check("ack",       32'(bus.ack),       32'(e_ack));
        check("sel",       32'(bus.sel),       32'(m_sel));
        check("busy",      32'(bus.busy),      32'(m_busy));
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (r != 4'h0) begin
                for (int k = 3; k >= 0; k--) begin
                    if (r[(m_ptr + k) % 4]) m_sel = (m_ptr + k) % 4;
                end
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end else if (!r[m_sel]) begin
            m_busy = 1'b0;
            m_ptr  = (m_sel + 1) % 4;
            m_cnt  = 0;
        end else if (rdy) begin
            m_cnt++;
            if (m_cnt == MAX_BURST) begin
                m_busy = 1'b0;
                m_ptr  = (m_sel + 1) % 4;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            run_cycle(4'b1111, 1'b1, 4'h5, 4'h6, 4'h7, 4'h8);
            check("rst_grant", 32'(bus.grant),     32'h0);
            check("rst_sel",   32'(bus.sel),       32'h0);
            check("rst_valid", 32'(bus.out_valid), 32'h0);
            check("rst_out",   32'(bus.out),       32'h0);
            check("rst_ack",   32'(bus.ack),       32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t2 [5]  = '{0, 4, 4, 0, 4};
        int t3 [14] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1};
        int t6 [4]  = '{0, 4, 4, 0};
        bus.req = '0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;

        // Single requester c: two-beat burst, bubble, re-grant after pointer wrap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_cycle(4'b0100, 1'b1, 4'h1, 4'h2, 4'h9, 4'h3);
            check("t2_grant", 32'(bus.grant), 32'(t2[i]));
            check("t2_ack",   32'(bus.ack),   32'(t2[i]));
        end

        // All requesting: rotation 0,1,2,3,0 with two beats each
        do_reset();
        for (int i = 0; i < 14; i++) begin
            run_cycle(4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
            check("t3_grant", 32'(bus.grant), 32'(t3[i]));
        end

        // Back-pressure on source b
        do_reset();
        run_cycle(4'b0010, 1'b0, 4'h0, 4'hA, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(4'b0010, 1'b0, 4'h0, 4'hA, 4'h0, 4'h0);
            check("t4_valid", 32'(bus.out_valid), 32'h1);
            check("t4_out",   32'(bus.out),       32'hA);
            check("t4_ack",   32'(bus.ack),       32'h0);
        end
        run_cycle(4'b0010, 1'b1, 4'h0, 4'hA, 4'h0, 4'h0);
        check("t4_ack4", 32'(bus.ack), 32'h2);

        // Source d drops its request mid-burst; pointer moves on to a
        do_reset();
        run_cycle(4'b1000, 1'b1, 4'h1, 4'h2, 4'h3, 4'hD);
        run_cycle(4'b1000, 1'b1, 4'h1, 4'h2, 4'h3, 4'hD);
        check("t5_ack1", 32'(bus.ack), 32'h8);
        run_cycle(4'b0001, 1'b1, 4'h1, 4'h2, 4'h3, 4'hD);
        check("t5_drop_valid", 32'(bus.out_valid), 32'h0);
        check("t5_drop_ack",   32'(bus.ack),       32'h0);
        run_cycle(4'b0001, 1'b1, 4'h1, 4'h2, 4'h3, 4'hD);
        check("t5_idle", 32'(bus.grant), 32'h0);
        run_cycle(4'b0001, 1'b1, 4'h1, 4'h2, 4'h3, 4'hD);
        check("t5_regrant", 32'(bus.grant), 32'h1);

        // Asynchronous reset mid-cycle while source c is granted
        do_reset();
        run_cycle(4'b0100, 1'b1, 4'h1, 4'h2, 4'h7, 4'h3);
        run_cycle(4'b0100, 1'b1, 4'h1, 4'h2, 4'h7, 4'h3);
        check("t6_pre_busy", 32'(bus.busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(bus.out_valid), 32'h0);
        check("t6_async_grant", 32'(bus.grant),     32'h0);
        check("t6_async_busy",  32'(bus.busy),      32'h0);
        check("t6_async_ack",   32'(bus.ack),       32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle(4'b0100, 1'b1, 4'h1, 4'h2, 4'h7, 4'h3);
            check("t6_ack", 32'(bus.ack), 32'(t6[i]));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            run_cycle(r, 1'($urandom_range(0, 3) != 0),
                      4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 data mux among four requesters. It grants a requester, drives the mux select, and presents the selected data downstream with a valid/ready handshake. A grant is held for a bounded burst. It sits between the four data sources (a, b, c, d) and a single consumer, and replaces free-running select stepping with request-driven scheduling.

Parameters:
WIDTH, 4, data width of each source and of out.
MAX_BURST, 2, maximum accepted transfers per grant before forced rotation (legal range 1..15).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  request per source; bit0=a, bit1=b, bit2=c, bit3=d.
a  input  WIDTH  source 0 data.
b  input  WIDTH  source 1 data.
c  input  WIDTH  source 2 data.
d  input  WIDTH  source 3 data.
out_ready  input  1  downstream can accept this cycle.
out_valid  output  1  out carries valid data from the granted source.
out  output  WIDTH  selected data; forced to 0 when out_valid=0.
sel  output  2  registered mux select (index of the current or last grant).
grant  output  4  registered one-hot grant; 0 in IDLE.
ack  output  4  one-hot, combinational; ack[sel]=out_valid&out_ready, others 0.
busy  output  1  1 in GRANT state.

Behaviour:
- Reset (async assert, no clock needed): state=IDLE, sel=0, grant=0, ptr=0, count=0, so out_valid=0, out=0, ack=0, busy=0. Deassertion is sampled on the next rising edge.
- Internal state: 2-state FSM {IDLE, GRANT}; round-robin pointer ptr[1:0]; burst counter count[3:0].
- IDLE: if req!=0, pick the first set bit scanning ptr, ptr+1, ... (mod 4). On the next edge: sel<=winner, grant<=onehot(winner), count<=0, state<=GRANT. If req==0, stay in IDLE and hold sel.
- GRANT: out_valid = req[sel]; out = source[sel] when out_valid, else 0. transfer = out_valid & out_ready.
  - On transfer: count<=count+1. If count+1==MAX_BURST, then state<=IDLE, grant<=0, ptr<=sel+1 (wraps 3->0).
  - If req[sel]==0: state<=IDLE, grant<=0, ptr<=sel+1, count<=0. No transfer occurs that cycle.
  - out_ready=0 with req[sel]=1: hold all state; out and out_valid stay stable (source data permitting).
- Fixed one-cycle IDLE bubble between grants; arbitration happens only in IDLE.
- Latency: data is visible at out one cycle after the edge that samples req in IDLE.
- Requests from non-granted sources are ignored in GRANT and are not latched. req is level-sensitive and must stay high until acked.
- count returns to 0 on every entry to GRANT. Only a transfer advances count.
- Async reset during GRANT aborts the burst immediately. Outputs drop to reset values with no ack.
- out data path is purely combinational from a/b/c/d through sel. WIDTH is arbitrary and there is no truncation.

Test Plan:
1. Hold rst=1 with req=4'b1111, a=4'h5 -> grant=0, sel=0, out_valid=0, out=0, ack=0 for every cycle of reset.
2. req=4'b0100, c=4'h9, out_ready=1 -> after 1 edge: grant=4'b0100, sel=2, out=4'h9, ack=4'b0100 for 2 cycles. Then IDLE (grant=0) for 1 cycle, then re-grant sel=2 (only requester; ptr=3 wraps).
3. req=4'b1111, out_ready=1 continuous -> sel sequence 0,0,idle,1,1,idle,2,2,idle,3,3,idle,0; each grant yields exactly 2 acks.
4. Grant on source 1 (b=4'hA), out_ready=0 for 3 cycles then 1 -> out_valid=1, out=4'hA, ack=0 for 3 cycles, count unchanged. The first ack arrives on cycle 4.
5. Grant on source 3; after 1 transfer drop req[3] while req[0]=1 -> next edge IDLE, ptr=0, count=0. The following edge grants sel=0.
6. Assert rst asynchronously mid-cycle during a GRANT on source 2 -> out_valid, grant, busy go to 0 before the next clk edge. After release with req=4'b0100, grant restarts with count=0.
